neuron_xnor: RTL and testbench

NEURON_XNOR -- requirements
Module: neuron_xnor

---
 rtl/bnn_pkg.sv | 21 ++
 rtl/bnn_popcount.sv | 35 +++
 rtl/neuron_xnor.sv | 99 +++++++++
 tb/tb_neuron_xnor.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared definitions for binary neural network blocks: synapse mode
// encodings and an elaboration-time width helper.
package bnn_pkg;

  // Synapse combine function selected by the chain's mode bit
  typedef enum logic {
    MODE_AND  = 1'b0,
    MODE_XNOR = 1'b1
  } mode_e;

  // Ceiling log2 for sizing; clog2(1) = 0, clog2(9) = 4
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bnn_popcount.sv
// Combinational popcount as a balanced binary adder tree. Leaves are
// zero-padded to a power of two so every level halves cleanly.
module bnn_popcount
  import bnn_pkg::*;
#(
  parameter int INPUTS   = 8,
  parameter int ACC_BITS = clog2(INPUTS + 1)
) (
  input  logic [INPUTS-1:0]   bits,
  output logic [ACC_BITS-1:0] count
);

  localparam int LVLS   = clog2(INPUTS);
  localparam int LEAVES = 1 << LVLS;

  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    localparam int N = LEAVES >> l;
    logic [ACC_BITS-1:0] s [N];
    for (genvar k = 0; k < N; k++) begin : g_node
      if (l == 0) begin : g_leaf
        if (k < INPUTS) begin : g_bit
          assign s[k] = ACC_BITS'(bits[k]);
        end else begin : g_pad
          assign s[k] = '0;
        end
      end else begin : g_add
        // Partial sums never exceed INPUTS, so ACC_BITS never overflows
        assign s[k] = g_lvl[l-1].s[2*k] + g_lvl[l-1].s[2*k+1];
      end
    end
  end

  assign count = g_lvl[LVLS].s[0];

endmodule

// File: rtl/neuron_xnor.sv
// Binary neuron: serially loaded weights/bias/mode, two-stage evaluation
// (synapse register, then popcount + threshold compare).
module neuron_xnor
  import bnn_pkg::*;
#(
  parameter  int INPUTS    = 8,
  parameter  int BIAS_BITS = 4,
  localparam int ACC_BITS  = clog2(INPUTS + 1),
  localparam int CHAIN_LEN = INPUTS + BIAS_BITS + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                setup,
  input  logic                param_in,
  output logic                param_out,
  input  logic                in_valid,
  input  logic [INPUTS-1:0]   inputs,
  output logic                out_valid,
  output logic                axon,
  output logic [ACC_BITS-1:0] count
);

  localparam int STAGES = 2;
  localparam int CMP_W  = (ACC_BITS > BIAS_BITS) ? ACC_BITS : BIAS_BITS;

  // chain = {mode, bias, weights}; shifting the whole vector left by one
  // moves weights MSB into bias LSB and bias MSB into mode.
  logic [CHAIN_LEN-1:0] chain;
  logic [INPUTS-1:0]    weights;
  logic [BIAS_BITS-1:0] bias;
  mode_e                mode;

  logic [INPUTS-1:0]    syn;
  logic [INPUTS-1:0]    syn_q;
  logic [ACC_BITS-1:0]  pc;
  logic [CMP_W-1:0]     cnt_x, bias_x;
  logic                 fire;
  logic [STAGES:1]      vld_pipe;

  assign weights   = chain[INPUTS-1:0];
  assign bias      = chain[INPUTS+BIAS_BITS-1:INPUTS];
  assign mode      = mode_e'(chain[CHAIN_LEN-1]);
  assign param_out = chain[CHAIN_LEN-1];

  // Shifting parameters and evaluating are mutually exclusive on an edge
  assign fire = in_valid & ~setup;

  for (genvar i = 0; i < INPUTS; i++) begin : g_syn
    assign syn[i] = (mode == MODE_XNOR) ? ~(weights[i] ^ inputs[i])
                                        : (weights[i] & inputs[i]);
  end

  bnn_popcount #(
    .INPUTS   (INPUTS),
    .ACC_BITS (ACC_BITS)
  ) u_pc (
    .bits  (syn_q),
    .count (pc)
  );

  // Zero-extend both operands so the threshold compare is unsigned
  assign cnt_x  = CMP_W'(pc);
  assign bias_x = CMP_W'(bias);

  // Parameter chain shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     chain <= '0;
    else if (setup) chain <= {chain[CHAIN_LEN-2:0], param_in};
  end

  // Stage 1: capture synapses; setup flushes the valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syn_q       <= '0;
      vld_pipe[1] <= 1'b0;
    end else begin
      vld_pipe[1] <= fire;
      if (fire) syn_q <= syn;
    end
  end

  // Stage 2: popcount and threshold; results hold when not updated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[2] <= 1'b0;
      count       <= '0;
      axon        <= 1'b0;
    end else begin
      vld_pipe[2] <= vld_pipe[1] & ~setup;
      if (vld_pipe[1] && !setup) begin
        count <= pc;
        axon  <= (cnt_x > bias_x);
      end
    end
  end

  assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_neuron_xnor.sv
// Scoreboard bench for neuron_xnor: stimulus pushes expected results, a
// monitor pops and compares on every out_valid pulse.
module tb_neuron_xnor;

  localparam int INPUTS    = 8;
  localparam int BIAS_BITS = 4;

  typedef struct {
    int cnt;
    int ax;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        setup;
  logic        param_in;
  logic        param_out;
  logic        in_valid;
  logic [7:0]  inputs;
  logic        out_valid;
  logic        axon;
  logic [3:0]  count;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  neuron_xnor #(
    .INPUTS    (INPUTS),
    .BIAS_BITS (BIAS_BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .setup     (setup),
    .param_in  (param_in),
    .param_out (param_out),
    .in_valid  (in_valid),
    .inputs    (inputs),
    .out_valid (out_valid),
    .axon      (axon),
    .count     (count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every out_valid pulse must match the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("count",   int'(count), e.cnt);
          chk("axon",    int'(axon),  e.ax);
          chk("latency", cyc,         e.cyc);
        end
      end
    end
  end

  // Shift mode, bias[3..0], weights[7..0] (13 bits, MSB first)
  task automatic load(input logic m, input logic [3:0] b, input logic [7:0] w);
    logic [12:0] v;
    v = {m, b, w};
    for (int i = 12; i >= 0; i--) begin
      setup    = 1'b1;
      param_in = v[i];
      @(posedge clk); #1;
    end
    setup    = 1'b0;
    param_in = 1'b0;
  endtask

  task automatic eval(input logic [7:0] x, input int ec, input int ea);
    exp_t e;
    in_valid = 1'b1;
    inputs   = x;
    e.cnt = ec; e.ax = ea; e.cyc = cyc + 2;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; setup = 1'b0; param_in = 1'b0; in_valid = 1'b0; inputs = '0;
    idle(2);
    chk("rst_count",     int'(count),     0);
    chk("rst_axon",      int'(axon),      0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_param_out", int'(param_out), 0);
    rst_n = 1'b1;
    idle(2);

    // AND mode, bias 3
    load(1'b0, 4'd3, 8'hFF);
    eval(8'h0F, 4, 1);
    idle(3);
    eval(8'h07, 3, 0);
    idle(3);

    // Streaming, AND mode, bias 1
    load(1'b0, 4'd1, 8'hFF);
    eval(8'h01, 1, 0);
    eval(8'h03, 2, 1);
    eval(8'h07, 3, 1);
    idle(4);

    // Flush: bias 9 so old bias[3]=1 surfaces on param_out after one shift
    load(1'b0, 4'd9, 8'hFF);
    eval(8'h0F, 4, 0);
    idle(3);
    in_valid = 1'b1; inputs = 8'hFF;
    @(posedge clk); #1;
    in_valid = 1'b0; setup = 1'b1; param_in = 1'b0;
    @(posedge clk); #1;
    setup = 1'b0;
    chk("flush_out_valid", int'(out_valid), 0);
    chk("flush_count",     int'(count),     4);
    chk("flush_axon",      int'(axon),      0);
    chk("flush_param_out", int'(param_out), 1);
    idle(4);

    // Bias at INPUTS: full count still does not fire
    load(1'b0, 4'd8, 8'hFF);
    eval(8'hFF, 8, 0);
    idle(3);

    // XNOR mode, bias 5
    load(1'b1, 4'd5, 8'hF0);
    chk("xnor_param_out", int'(param_out), 1);
    eval(8'hF0, 8, 1);
    idle(3);
    eval(8'h0F, 0, 0);
    idle(3);
    eval(8'hF0, 8, 1);
    idle(3);

    // Reset mid-cycle with an evaluation in flight
    in_valid = 1'b1; inputs = 8'hF0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_count",     int'(count),     0);
    chk("mid_rst_axon",      int'(axon),      0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_param_out", int'(param_out), 0);
    idle(2);
    rst_n = 1'b1;
    idle(5);
    // Parameters cleared: mode AND, weights 0, bias 0
    eval(8'hFF, 0, 0);
    idle(3);

    // Chain readback: 1 then twelve 0s
    setup = 1'b1; param_in = 1'b1;
    @(posedge clk); #1;
    param_in = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("chain_12", int'(param_out), 0);
    @(posedge clk); #1;
    chk("chain_13", int'(param_out), 1);
    @(posedge clk); #1;
    setup = 1'b0;
    chk("chain_14", int'(param_out), 0);

    // Drain scoreboard with a bound
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
